// File: rtl/cv32e40p_pkg.sv
// Shared definitions for the instruction-bus arbiter slice.
//   ibus_owner_e               : identifies which requester issued a transaction
//   IBUS_MAX_OUTSTANDING_LIMIT : largest supported in-flight transaction count
//   IBUS_CNT_W                 : width of outstanding-count signals
package cv32e40p_pkg;

    typedef enum logic {
        IBUS_OWNER_CORE = 1'b0,
        IBUS_OWNER_LCE  = 1'b1
    } ibus_owner_e;

    localparam int unsigned IBUS_MAX_OUTSTANDING_LIMIT = 4;
    localparam int unsigned IBUS_CNT_W                 = 3;

endpackage

// File: rtl/cv32e40p_obi_owner_fifo.sv
// In-order FIFO of owner IDs for granted-but-unanswered OBI transactions.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push_i, owner_i : enqueue owner of a newly granted transaction
//   pop_i, owner_o  : dequeue head owner when its response returns
//   full_o, empty_o : occupancy flags
//   count_o         : current number of stored entries
// Simultaneous push and pop are supported (count unchanged).
module cv32e40p_obi_owner_fifo
    import cv32e40p_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  ibus_owner_e           owner_i,
    input  logic                  pop_i,
    output ibus_owner_e           owner_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [IBUS_CNT_W-1:0] count_o
);

    localparam logic [IBUS_CNT_W-1:0] DEPTH_C  = IBUS_CNT_W'(DEPTH);
    localparam logic [1:0]            PTR_LAST = 2'(DEPTH - 1);

    ibus_owner_e           mem_q [IBUS_MAX_OUTSTANDING_LIMIT];
    ibus_owner_e           mem_d [IBUS_MAX_OUTSTANDING_LIMIT];
    logic [1:0]            wptr_q, wptr_d;
    logic [1:0]            rptr_q, rptr_d;
    logic [IBUS_CNT_W-1:0] count_q, count_d;
    logic                  push_ok, pop_ok;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        full_o  = (count_q == DEPTH_C);
        empty_o = (count_q == '0);
        push_ok = push_i & ~full_o;
        pop_ok  = pop_i & ~empty_o;

        if (push_ok) begin
            mem_d[wptr_q] = owner_i;
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 2'd1;
        end
        if (pop_ok) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 2'd1;
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: IBUS_OWNER_CORE};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign owner_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/cv32e40p_instr_obi_arbiter.sv
// Shares one OBI instruction-memory port between the core fetch path (m0)
// and the linear-code-extraction engine (m1). Address phase is combinational;
// responses are routed in order to the issuing requester.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   m0_* / m1_*                       : requester-side OBI (req/addr in, gnt/rvalid/rdata/err out)
//   instr_*                           : memory-side OBI
//   outstanding_o                     : granted-but-unanswered transaction count
//   spurious_rvalid_o                 : sticky, response seen with an empty tracker
// Configuration macro:
//   CV32E40P_IBUS_ARB_RR_EN           : round-robin between simultaneous requesters
//                                       (undefined: fixed priority, m0 wins)
module cv32e40p_instr_obi_arbiter
    import cv32e40p_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    output logic                  m0_err_o,
    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  m1_err_o,
    output logic                  instr_req_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [DATA_WIDTH-1:0] instr_rdata_i,
    input  logic                  instr_err_i,
    output logic [2:0]            outstanding_o,
    output logic                  spurious_rvalid_o
);

    logic                  lock_q, lock_d;
    ibus_owner_e           lock_owner_q, lock_owner_d;
    logic                  spurious_q, spurious_d;
`ifdef CV32E40P_IBUS_ARB_RR_EN
    ibus_owner_e           rr_ptr_q, rr_ptr_d;
`endif

    ibus_owner_e           sel_owner;
    ibus_owner_e           head_owner;
    logic                  sel_req;
    logic                  push, pop;
    logic                  fifo_full, fifo_empty;
    logic [IBUS_CNT_W-1:0] fifo_count;

    cv32e40p_obi_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .owner_i (sel_owner),
        .pop_i   (pop),
        .owner_o (head_owner),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        // A pending ungranted request keeps its owner so the address phase
        // cannot change under the memory.
        sel_owner = IBUS_OWNER_CORE;
        if (lock_q) begin
            sel_owner = lock_owner_q;
`ifdef CV32E40P_IBUS_ARB_RR_EN
        end else if (m0_req_i && m1_req_i) begin
            sel_owner = rr_ptr_q;
`endif
        end else if (!m0_req_i && m1_req_i) begin
            sel_owner = IBUS_OWNER_LCE;
        end

        sel_req = (sel_owner == IBUS_OWNER_CORE) ? m0_req_i : m1_req_i;

        // Tracker full means no further grant can be recorded.
        instr_req_o  = sel_req & ~fifo_full & ~rst;
        instr_addr_o = rst ? '0 :
                       (sel_owner == IBUS_OWNER_CORE) ? m0_addr_i : m1_addr_i;

        push = instr_req_o & instr_gnt_i;
        pop  = instr_rvalid_i & ~fifo_empty & ~rst;

        m0_gnt_o    = push & (sel_owner == IBUS_OWNER_CORE);
        m1_gnt_o    = push & (sel_owner == IBUS_OWNER_LCE);
        m0_rvalid_o = pop & (head_owner == IBUS_OWNER_CORE);
        m1_rvalid_o = pop & (head_owner == IBUS_OWNER_LCE);
        m0_rdata_o  = rst ? '0 : instr_rdata_i;
        m1_rdata_o  = rst ? '0 : instr_rdata_i;
        m0_err_o    = m0_rvalid_o & instr_err_i;
        m1_err_o    = m1_rvalid_o & instr_err_i;

        lock_d       = instr_req_o & ~instr_gnt_i;
        lock_owner_d = sel_owner;
        spurious_d   = spurious_q | (instr_rvalid_i & fifo_empty);

`ifdef CV32E40P_IBUS_ARB_RR_EN
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (sel_owner == IBUS_OWNER_CORE) ? IBUS_OWNER_LCE : IBUS_OWNER_CORE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q       <= 1'b0;
            lock_owner_q <= IBUS_OWNER_CORE;
            spurious_q   <= 1'b0;
`ifdef CV32E40P_IBUS_ARB_RR_EN
            rr_ptr_q     <= IBUS_OWNER_CORE;
`endif
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            spurious_q   <= spurious_d;
`ifdef CV32E40P_IBUS_ARB_RR_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign outstanding_o     = fifo_count;
    assign spurious_rvalid_o = spurious_q;

endmodule

// File: tb/tb_cv32e40p_instr_obi_arbiter.sv
module tb_cv32e40p_instr_obi_arbiter;

    localparam int MAXO   = 2;
    localparam int NCYC   = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m1_req_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic        m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0] instr_rdata_i;
    logic [2:0]  outstanding_o;
    logic        spurious_rvalid_o;

    cv32e40p_instr_obi_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .m0_req_i          (m0_req_i),
        .m0_addr_i         (m0_addr_i),
        .m0_gnt_o          (m0_gnt_o),
        .m0_rvalid_o       (m0_rvalid_o),
        .m0_rdata_o        (m0_rdata_o),
        .m0_err_o          (m0_err_o),
        .m1_req_i          (m1_req_i),
        .m1_addr_i         (m1_addr_i),
        .m1_gnt_o          (m1_gnt_o),
        .m1_rvalid_o       (m1_rvalid_o),
        .m1_rdata_o        (m1_rdata_o),
        .m1_err_o          (m1_err_o),
        .instr_req_o       (instr_req_o),
        .instr_addr_o      (instr_addr_o),
        .instr_gnt_i       (instr_gnt_i),
        .instr_rvalid_i    (instr_rvalid_i),
        .instr_rdata_i     (instr_rdata_i),
        .instr_err_i       (instr_err_i),
        .outstanding_o     (outstanding_o),
        .spurious_rvalid_o (spurious_rvalid_o)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {int owner; logic [31:0] data; logic err;} resp_t;
    typedef struct {logic [31:0] data; logic err; bit stale;} mem_t;

    resp_t exp_resp[$];   // scoreboard: responses the requesters should see, in order
    mem_t  mem_pend[$];   // memory model: accepted transactions awaiting a response
    int    trk[$];        // reference tracker: owners of granted, unanswered transactions

    bit          m_lock;
    int          m_lock_owner;
    int          m_ptr;
    bit          m_spur;
    int          stale_cnt;
    bit          r_req[2];
    logic [31:0] r_addr[2];
    bit          last_gnt[2];
    int          p_req, p_gnt, p_rv;

    function automatic bit chance(int pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard whenever a requester sees rvalid.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            #1;
            if (m0_rvalid_o && m1_rvalid_o) chk("resp_both_valid", 32'd1, 32'd0);
            if (m0_rvalid_o || m1_rvalid_o) begin
                if (exp_resp.size() == 0) begin
                    chk("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    r = exp_resp.pop_front();
                    chk("resp_owner", m1_rvalid_o ? 32'd1 : 32'd0, 32'(r.owner));
                    chk("resp_data", m1_rvalid_o ? m1_rdata_o : m0_rdata_o, r.data);
                    chk("resp_err", {31'd0, m1_rvalid_o ? m1_err_o : m0_err_o}, {31'd0, r.err});
                end
            end
        end
    end

    initial begin
        int    o;
        bit    full, e_req, g;
        bit    e_rv[2];
        mem_t  m;
        resp_t r;

        rst = 1'b1;
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        m0_addr_i = '0;  m1_addr_i = '0;
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
        instr_rdata_i = '0; instr_err_i = 1'b0;
        m_lock = 0; m_lock_owner = 0; m_ptr = 0; m_spur = 0; stale_cnt = 0;
        r_req = '{0, 0}; r_addr = '{32'd0, 32'd0}; last_gnt = '{0, 0};
        p_req = 60; p_gnt = 60; p_rv = 50;
        @(posedge clk);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            #1;
            if (cyc % 300 == 0) begin
                p_req = (cyc % 900 == 300) ? 100 : 20 + 40 * $urandom_range(2, 0);
                p_gnt = 30 + 35 * $urandom_range(2, 0);
                p_rv  = 10 + 40 * $urandom_range(2, 0);
            end

            rst = (cyc < 3) || ($urandom_range(399, 0) == 0);

            // Requesters: hold req+addr until granted; stay quiet while
            // responses from before a reset are still draining.
            for (int i = 0; i < 2; i++) begin
                if (stale_cnt > 0) begin
                    r_req[i] = 0;
                end else if (!r_req[i] || last_gnt[i]) begin
                    r_req[i]  = chance(p_req);
                    r_addr[i] = $urandom & 32'hFFFF_FFFC;
                end
            end
            m0_req_i = r_req[0]; m0_addr_i = r_addr[0];
            m1_req_i = r_req[1]; m1_addr_i = r_addr[1];

            instr_gnt_i   = chance(p_gnt);
            instr_rdata_i = $urandom;
            instr_err_i   = $urandom_range(1, 0) == 1;
            instr_rvalid_i = 1'b0;
            if (mem_pend.size() > 0 && chance(p_rv)) begin
                m = mem_pend.pop_front();
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = m.data;
                instr_err_i    = m.err;
                if (m.stale) stale_cnt--;
            end else if (mem_pend.size() == 0 && chance(3)) begin
                instr_rvalid_i = 1'b1;
            end

            @(negedge clk);
            e_rv = '{0, 0};
            if (rst) begin
                chk("rst_req", {31'd0, instr_req_o}, 32'd0);
                chk("rst_addr", instr_addr_o, 32'd0);
                chk("rst_gnt0", {31'd0, m0_gnt_o}, 32'd0);
                chk("rst_gnt1", {31'd0, m1_gnt_o}, 32'd0);
                chk("rst_rv0", {31'd0, m0_rvalid_o}, 32'd0);
                chk("rst_rv1", {31'd0, m1_rvalid_o}, 32'd0);
                chk("rst_rdata0", m0_rdata_o, 32'd0);
                chk("rst_rdata1", m1_rdata_o, 32'd0);
                chk("outstanding", {29'd0, outstanding_o}, 32'(trk.size()));
                chk("spurious", {31'd0, spurious_rvalid_o}, {31'd0, m_spur});
                trk.delete();
                exp_resp.delete();
                m_lock = 0; m_ptr = 0; m_spur = 0;
                last_gnt = '{0, 0};
                for (int i = 0; i < mem_pend.size(); i++) begin
                    if (!mem_pend[i].stale) begin
                        mem_pend[i].stale = 1;
                        stale_cnt++;
                    end
                end
            end else begin
                full = (trk.size() == MAXO);
                if (m_lock) o = m_lock_owner;
                else if (r_req[0] && r_req[1]) begin
`ifdef CV32E40P_IBUS_ARB_RR_EN
                    o = m_ptr;
`else
                    o = 0;
`endif
                end else if (r_req[1]) o = 1;
                else o = 0;

                e_req = r_req[o] && !full;
                g     = e_req && instr_gnt_i;
                if (instr_rvalid_i && trk.size() > 0) e_rv[trk[0]] = 1;

                chk("instr_req", {31'd0, instr_req_o}, {31'd0, e_req});
                if (e_req) chk("instr_addr", instr_addr_o, r_addr[o]);
                chk("gnt0", {31'd0, m0_gnt_o}, {31'd0, g && o == 0});
                chk("gnt1", {31'd0, m1_gnt_o}, {31'd0, g && o == 1});
                chk("rv0", {31'd0, m0_rvalid_o}, {31'd0, e_rv[0]});
                chk("rv1", {31'd0, m1_rvalid_o}, {31'd0, e_rv[1]});
                if (e_rv[0]) chk("err0", {31'd0, m0_err_o}, {31'd0, instr_err_i});
                if (e_rv[1]) chk("err1", {31'd0, m1_err_o}, {31'd0, instr_err_i});
                chk("outstanding", {29'd0, outstanding_o}, 32'(trk.size()));
                chk("spurious", {31'd0, spurious_rvalid_o}, {31'd0, m_spur});

                if (instr_rvalid_i && trk.size() == 0) m_spur = 1;
                if (instr_rvalid_i && trk.size() > 0) void'(trk.pop_front());
                if (g) begin
                    trk.push_back(o);
                    m_ptr = 1 - o;
                    m.data  = $urandom;
                    m.err   = chance(10);
                    m.stale = 0;
                    mem_pend.push_back(m);
                    r.owner = o; r.data = m.data; r.err = m.err;
                    exp_resp.push_back(r);
                end
                m_lock       = e_req && !instr_gnt_i;
                m_lock_owner = o;
                last_gnt[0]  = g && o == 0;
                last_gnt[1]  = g && o == 1;
            end
            @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
